// File: rtl/midi_tx_queue.sv
// midi_tx_queue: byte FIFO plus feeder FSM in front of uart_tx on a MIDI OUT port.
// The router pushes bytes at full clock rate. This block queues them and hands them one
// at a time to uart_tx over the tx_strobe/tx_data/tx_busy handshake. uart_tx samples only
// on clk_en, so each strobe is held until busy is seen or the byte is abandoned.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   clk_en            the enable that also drives uart_tx; paces the give-up timer
//   wr_en, wr_data    push one byte
//   flush             drop every queued byte (an in-flight byte is unaffected)
//   full, empty       queue status derived from count (in-flight byte not counted)
//   count             queued bytes, 0..DEPTH
//   overflow          sticky flag: a push was dropped; cleared by flush
//   tx_strobe/tx_data request to uart_tx; tx_data is stable while tx_strobe=1
//   tx_busy           uart_tx frame in progress
//   timeout           one-cycle pulse when a byte is abandoned
//
// state     | meaning
// IDLE      | no byte in flight; pops the head when uart_tx is free
// STROBE    | tx_strobe held, waiting for uart_tx to raise busy
// WAIT_DONE | frame in progress, waiting for busy to fall
module midi_tx_queue #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        tx_strobe,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE} state_t;

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [7:0]  TCNT_INIT = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          tx_strobe_q, tx_strobe_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          pop, wr_ok, wr_drop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_strobe = tx_strobe_q;
  assign tx_data   = tx_data_q;
  assign timeout   = timeout_q;

  // A flush clears the head too, so no pop is taken in a flush cycle.
  // A push into a full queue still lands when the head leaves in the same cycle.
  always_comb begin
    pop     = (state_q == IDLE) && !empty && !tx_busy && !flush;
    wr_ok   = wr_en && !flush && (!full || pop);
    wr_drop = wr_en && !flush && full && !pop;

    wr_ptr_d   = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d   = flush ? wr_ptr_q : (rd_ptr_q + AW'(pop));
    overflow_d = flush ? 1'b0 : (overflow_q | wr_drop);

    count_d = count_q;
    if (flush)              count_d = '0;
    else if (wr_ok && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !wr_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_strobe_q <= 1'b0;
      tx_data_q   <= 8'h00;
      timeout_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      tx_strobe_q <= tx_strobe_d;
      tx_data_q   <= tx_data_d;
      timeout_q   <= timeout_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Give-up timer counts clk_en ticks down from TIMEOUT; the byte is abandoned on the
  // tick that finds it at zero, i.e. TIMEOUT+1 ticks after the strobe went up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = STROBE;
      STROBE: begin
        if (tx_busy)                         state_d = WAIT_DONE;
        else if (clk_en && (tcnt_q == '0))   state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_strobe_d = tx_strobe_q;
    tx_data_d   = tx_data_q;
    timeout_d   = 1'b0;
    tcnt_d      = tcnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d   = mem_q[rd_ptr_q];
          tx_strobe_d = 1'b1;
          tcnt_d      = TCNT_INIT;
        end
      end
      STROBE: begin
        if (tx_busy) begin
          tx_strobe_d = 1'b0;
        end else if (clk_en) begin
          if (tcnt_q == '0) begin
            tx_strobe_d = 1'b0;
            timeout_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q - 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_midi_tx_queue.sv
// Bench for midi_tx_queue: a queue-level reference model plus a small uart_tx stand-in,
// compared against the DUT one cycle at a time, with literal spot checks per scenario.
module tb_midi_tx_queue;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_busy = 1'b0;
  logic       full, empty, overflow, tx_strobe, timeout;
  logic [4:0] count;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  midi_tx_queue #(.DEPTH(16), .AW(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_strobe(tx_strobe), .tx_data(tx_data), .tx_busy(tx_busy), .timeout(timeout)
  );

  int checks = 0;
  int failures = 0;

  // reference model: queue contents plus in-flight phase (0 none, 1 strobing, 2 frame)
  byte unsigned mq[$];
  bit           m_ovf, m_strobe, m_tout;
  logic [7:0]   m_data;
  int           m_phase, m_ticks;

  // uart_tx stand-in: mode 0 normal, 1 busy forced high, 2 busy stuck low
  int           umode = 0;
  int           uleft = 0;
  bit           ce_rand = 0;
  byte unsigned frames[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_strobe = 0; m_tout = 0; m_data = 8'h00; m_phase = 0; m_ticks = 0;
  endtask

  task automatic model_edge();
    bit pop;
    pop = (m_phase == 0) && (mq.size() > 0) && !tx_busy && !flush;
    m_tout = 0;
    case (m_phase)
      0: if (pop) begin
        m_data = mq.pop_front(); m_strobe = 1; m_ticks = 0; m_phase = 1;
      end
      1: if (tx_busy) begin
        m_strobe = 0; m_phase = 2;
      end else if (clk_en) begin
        if (m_ticks == 255) begin m_strobe = 0; m_tout = 1; m_phase = 0; end
        else m_ticks++;
      end
      default: if (!tx_busy) m_phase = 0;
    endcase
    if (flush) begin
      mq.delete(); m_ovf = 0;
    end else if (wr_en) begin
      if (mq.size() < DEPTH) mq.push_back(wr_data);
      else m_ovf = 1;
    end
  endtask

  task automatic uart_edge(input bit strobe_pre, input bit ce);
    case (umode)
      0: begin
        if (tx_busy) begin
          if (ce) begin
            uleft--;
            if (uleft == 0) tx_busy = 1'b0;
          end
        end else if (ce && strobe_pre) begin
          tx_busy = 1'b1;
          uleft = ce_rand ? int'($urandom_range(1, 5)) : 4;
          frames.push_back(tx_data);
        end
      end
      1: tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_strobe", 32'(tx_strobe), 32'(m_strobe));
    chk("timeout", 32'(timeout), 32'(m_tout));
    if (m_strobe) chk("tx_data", 32'(tx_data), 32'(m_data));
  endtask

  task automatic step();
    bit sp, ce;
    @(posedge clk);
    #1;
    sp = m_strobe;
    ce = clk_en;
    if (rst_n) model_edge(); else model_reset();
    uart_edge(sp, ce);
    check_all();
    clk_en = ce_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!(mq.size() == 0 && m_phase == 0 && !tx_busy) && n < bound) begin
      step(); n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  initial begin
    byte unsigned exp_q[$];
    logic [7:0] b;
    int n;

    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    step();

    // single byte: latency and frame content
    frames.delete();
    push(8'h90);
    chk("single_cnt1", 32'(count), 32'd1);
    chk("single_nostrobe", 32'(tx_strobe), 32'd0);
    step();
    chk("single_strobe", 32'(tx_strobe), 32'd1);
    chk("single_data", 32'(tx_data), 32'h90);
    chk("single_cnt0", 32'(count), 32'd0);
    wait_idle("single_done", 200);
    chk("single_frames", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) chk("single_frame0", 32'(frames[0]), 32'h90);

    // burst of three
    frames.delete();
    push(8'h90); push(8'h3C); push(8'h7F);
    wait_idle("burst_done", 500);
    chk("burst_frames", 32'(frames.size()), 32'd3);
    if (frames.size() == 3) begin
      chk("burst_f0", 32'(frames[0]), 32'h90);
      chk("burst_f1", 32'(frames[1]), 32'h3C);
      chk("burst_f2", 32'(frames[2]), 32'h7F);
    end

    // reset mid-byte
    push(8'hA5); push(8'h5A);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_strobe", 32'(tx_strobe), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'h00);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("postrst_empty", 32'(empty), 32'd1);
    chk("postrst_count", 32'(count), 32'd0);
    wait_idle("postrst_idle", 200);

    // full and overflow with busy forced high
    umode = 1; tx_busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push(b);
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    frames.delete();
    umode = 0; tx_busy = 1'b0; uleft = 0;
    wait_idle("ovf_drain", 2000);
    chk("ovf_frames", 32'(frames.size()), 32'd16);
    for (int i = 0; i < 16 && i < frames.size(); i++)
      chk("ovf_order", 32'(frames[i]), 32'(exp_q[i]));

    // push and pop together while full, across pointer wrap
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_ovf", 32'(overflow), 32'd0);
    umode = 1; tx_busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      push(b);
    end
    frames.delete();
    umode = 0; tx_busy = 1'b0; uleft = 0;
    exp_q.push_back(8'hC3);
    push(8'hC3);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_ovf", 32'(overflow), 32'd0);
    wait_idle("simul_drain", 2000);
    chk("simul_frames", 32'(frames.size()), 32'd17);
    for (int i = 0; i < 17 && i < frames.size(); i++)
      chk("simul_order", 32'(frames[i]), 32'(exp_q[i]));

    // flush with a byte in flight
    frames.delete();
    push(8'h11); push(8'h22); push(8'h33);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);
    wait_idle("fl_drain", 300);
    chk("fl_frames", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) chk("fl_frame0", 32'(frames[0]), 32'h11);

    // timeout: uart never answers
    umode = 2; tx_busy = 1'b0;
    push(8'hD1); push(8'hE2);
    n = 0;
    while (!tx_strobe && n < 20) begin step(); n++; end
    n = 0;
    while (!timeout && n < 400) begin step(); n++; end
    chk("tout_ticks", 32'(n), 32'd256);
    chk("tout_strobe", 32'(tx_strobe), 32'd0);
    step();
    chk("tout_next_strobe", 32'(tx_strobe), 32'd1);
    chk("tout_next_data", 32'(tx_data), 32'hE2);
    umode = 0;
    wait_idle("tout_idle", 300);

    // randomized traffic
    ce_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 500) == 100) umode = 1;
      if ((c % 500) == 160) begin umode = 0; tx_busy = 1'b0; uleft = 0; end
      wr_en = ($urandom_range(0, 1) == 1);
      wr_data = 8'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_en = 1'b0; flush = 1'b0; umode = 0;
    wait_idle("rand_drain", 5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
